instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, address of the first instruction after reset SHALL be used.
REQ-002 Parameter PC_STEP, default 16'd1, SHALL be the PC increment per delivered instruction (word addressing).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 fetch_req  input  1  controller request for the next instruction; SHALL be sampled only while busy=0 (or as per REQ-020).
REQ-006 redirect  input  1  branch/jump; SHALL load redirect_pc into pc.
REQ-007 redirect_pc  input  16  redirect target address.
REQ-008 mem_addr  output  16  instruction memory address.
REQ-009 mem_rd_en  output  1  one-cycle read strobe.
REQ-010 mem_rdata  input  16  read data, valid when mem_valid=1.
REQ-011 mem_valid  input  1  read response, at least 1 cycle after mem_rd_en.
REQ-012 instr_out  output  16  fetched instruction, feeds instruction register data input.
REQ-013 load_en  output  1  one-cycle pulse, feeds instruction register load enable; instr_out SHALL be valid whenever load_en=1.
REQ-014 pc  output  16  address of the next instruction to deliver.
REQ-015 busy  output  1  high whenever the FSM state is not IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DRAIN. Each state SHALL behave as follows:
- IDLE -> ISSUE when fetch_req=1.
- ISSUE drives mem_rd_en=1 and mem_addr=pc for exactly one cycle, then moves to WAIT.
- WAIT -> IDLE on mem_valid.
- DRAIN -> IDLE on mem_valid.
REQ-017 On mem_valid in WAIT, the block SHALL register instr_out<=mem_rdata, assert load_en the next cycle only, and set pc<=pc+PC_STEP.
REQ-018 Latency SHALL be as follows: fetch_req sampled at edge N gives mem_rd_en in cycle N+1. mem_valid at edge M gives load_en high in cycle M+1, so the minimum is 3 cycles from request to load_en.
REQ-019 The PC SHALL use modulo-2^16 arithmetic: 16'hFFFF+1 SHALL wrap to 16'h0000 with no flag.
REQ-020 fetch_req SHALL be ignored while busy=1, except where REQ-031 applies.
REQ-021 redirect SHALL have highest priority in every state and SHALL set pc<=redirect_pc that edge.
REQ-022 redirect in IDLE SHALL keep the FSM in IDLE, and any fetch_req in the same cycle SHALL be ignored.
REQ-023 redirect in ISSUE or WAIT without mem_valid SHALL move the FSM to DRAIN. The outstanding response SHALL be discarded, with no load_en and no change to instr_out.
REQ-024 redirect in WAIT with mem_valid in the same cycle SHALL discard the data, give no load_en, and return the FSM to IDLE.
REQ-025 redirect in DRAIN SHALL update pc and leave the FSM in DRAIN.
REQ-026 mem_valid in IDLE or ISSUE SHALL be ignored.
REQ-027 mem_rd_en SHALL never be asserted while a read is outstanding (at most one outstanding read).

Reset
REQ-028 With reset=0 at a rising edge, the block SHALL take the following values:
- state=IDLE, pc=RESET_PC, instr_out=16'h0000;
- load_en=0, mem_rd_en=0, mem_addr=16'h0000, busy=0;
- prefetch buffer invalid.
REQ-029 Reset mid-fetch SHALL abandon the outstanding read, and later mem_valid SHALL be ignored (REQ-026).

Configuration
REQ-030 Macro IFETCH_PREFETCH_EN SHALL select the prefetch feature; when it is undefined the block SHALL behave exactly per REQ-016..REQ-029 with no buffer logic.
REQ-031 When defined, the following SHALL apply:
- After each delivery, and after reset or redirect, the block SHALL issue a speculative read of pc into a one-entry buffer.
- fetch_req in IDLE with buffer valid SHALL give load_en next cycle with instr_out=buffer, pc+=PC_STEP, then a new prefetch.
- fetch_req during an outstanding prefetch SHALL be recorded as pending and delivered the cycle after mem_valid.
- redirect SHALL invalidate the buffer and clear pending.

Verification
REQ-032 Scenario 1: reset, then fetch_req=1 for one cycle, with memory returning 16'h1234 at address 0x0000 on the second cycle after mem_rd_en. The bench SHALL check mem_addr=0x0000, exactly one load_en with instr_out=16'h1234, then pc=0x0001 and busy=0.
REQ-033 Scenario 2: with pc=16'hFFFF, one fetch. The bench SHALL check mem_addr=0xFFFF and pc=0x0000 after load_en.
REQ-034 Scenario 3: fetch issued, then redirect=1 with redirect_pc=0x0040 during WAIT. The bench SHALL check no load_en on the stale response, pc=0x0040, and that the next fetch reads 0x0040.
REQ-035 Scenario 4: redirect in the same cycle as mem_valid. The bench SHALL check no load_en, instr_out unchanged, and state IDLE.
REQ-036 Scenario 5: reset pulsed low during WAIT, then a late mem_valid with 16'hBEEF. The bench SHALL check load_en=0, instr_out=0x0000 and pc=RESET_PC. With IFETCH_PREFETCH_EN, a fetch_req after the buffer fills SHALL give load_en the next cycle.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: issues single reads to instruction memory and hands the
// word to the instruction register. Optional one-entry prefetch: IFETCH_PREFETCH_EN.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic [15:0] instr_out,
    output logic        load_en,
    output logic [15:0] pc,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] instr_reg, instr_next;
    logic        load_en_reg, load_en_next;

`ifdef IFETCH_PREFETCH_EN
    logic [15:0] buf_reg, buf_next;
    logic        buf_valid_reg, buf_valid_next;
    logic        pending_reg, pending_next;

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        instr_next     = instr_reg;
        load_en_next   = 1'b0;
        buf_next       = buf_reg;
        buf_valid_next = buf_valid_reg;
        pending_next   = pending_reg;

        if (redirect) begin
            pc_next        = redirect_pc;
            buf_valid_next = 1'b0;
            pending_next   = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (!redirect) begin
                    if (buf_valid_reg) begin
                        if (fetch_req) begin
                            instr_next     = buf_reg;
                            load_en_next   = 1'b1;
                            pc_next        = pc_reg + PC_STEP;
                            buf_valid_next = 1'b0;
                        end
                    end else begin
                        // Empty buffer: refill speculatively, remembering any request.
                        state_next   = ISSUE;
                        pending_next = pending_reg | fetch_req;
                    end
                end
            end
            ISSUE: begin
                state_next = redirect ? DRAIN : WAIT;
                if (!redirect && fetch_req) begin
                    pending_next = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_next = mem_valid ? IDLE : DRAIN;
                end else if (mem_valid) begin
                    state_next = IDLE;
                    if (pending_reg || fetch_req) begin
                        instr_next   = mem_rdata;
                        load_en_next = 1'b1;
                        pc_next      = pc_reg + PC_STEP;
                        pending_next = 1'b0;
                    end else begin
                        buf_next       = mem_rdata;
                        buf_valid_next = 1'b1;
                    end
                end else if (fetch_req) begin
                    pending_next = 1'b1;
                end
            end
            DRAIN: begin
                if (!redirect && fetch_req) begin
                    pending_next = 1'b1;
                end
                if (mem_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_reg       <= 16'h0000;
            buf_valid_reg <= 1'b0;
            pending_reg   <= 1'b0;
        end else begin
            buf_reg       <= buf_next;
            buf_valid_reg <= buf_valid_next;
            pending_reg   <= pending_next;
        end
    end
`else
    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        instr_next   = instr_reg;
        load_en_next = 1'b0;

        if (redirect) begin
            pc_next = redirect_pc;
        end

        case (state_reg)
            IDLE: begin
                if (!redirect && fetch_req) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = redirect ? DRAIN : WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    // A response landing with the redirect is stale; drop it.
                    state_next = mem_valid ? IDLE : DRAIN;
                end else if (mem_valid) begin
                    state_next   = IDLE;
                    instr_next   = mem_rdata;
                    load_en_next = 1'b1;
                    pc_next      = pc_reg + PC_STEP;
                end
            end
            DRAIN: begin
                // Redirect only retargets pc here; the outstanding read still has to return.
                if (mem_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            pc_reg      <= RESET_PC;
            instr_reg   <= 16'h0000;
            load_en_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            instr_reg   <= instr_next;
            load_en_reg <= load_en_next;
        end
    end

    assign mem_rd_en = (state_reg == ISSUE);
    assign mem_addr  = mem_rd_en ? pc_reg : 16'h0000;
    assign instr_out = instr_reg;
    assign load_en   = load_en_reg;
    assign pc        = pc_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: reset, table-driven fetches, and
// hand-written redirect/reset corner sequences with a load_en scoreboard.
module tb_instr_fetch;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] STEP   = 16'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] instr_out;
    logic        load_en;
    logic [15:0] pc;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] start_pc;
        int          lat;
        logic [15:0] data;
        logic [15:0] next_pc;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC(RST_PC),
        .PC_STEP (STEP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .instr_out  (instr_out),
        .load_en    (load_en),
        .pc         (pc),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and score any load_en pulse against the queue.
    task automatic tick();
        logic [15:0] exp;
        @(negedge clk);
        if (load_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_load_en: got load_en=1 instr_out=%h required no load", instr_out);
            end else begin
                exp = exp_q.pop_front();
                if (instr_out !== exp) begin
                    failures++;
                    $display("FAIL load_data: got instr_out=%h required %h", instr_out, exp);
                end else begin
                    $display("load instr_out=%h pc=%h", instr_out, pc);
                end
            end
        end
    endtask

    task automatic set_pc(input logic [15:0] v);
        redirect    = 1'b1;
        redirect_pc = v;
        tick();
        redirect    = 1'b0;
        chk("set_pc", pc, v);
        chk1("set_pc_busy", busy, 1'b0);
    endtask

    // One complete fetch: mem_valid arrives lat cycles after the mem_rd_en cycle.
    task automatic do_fetch(input logic [15:0] addr, input int lat, input logic [15:0] data);
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk1("mem_rd_en", mem_rd_en, 1'b1);
        chk("mem_addr", mem_addr, addr);
        repeat (lat) begin
            tick();
            chk1("rd_en_single", mem_rd_en, 1'b0);
        end
        mem_valid = 1'b1;
        mem_rdata = data;
        exp_q.push_back(data);
        tick();
        mem_valid = 1'b0;
        chk1("load_en", load_en, 1'b1);
    endtask

    initial begin
        logic [15:0] prev_instr;

        vecs[0] = '{16'h0010, 1, 16'hA5A5, 16'h0011};
        vecs[1] = '{16'hFFFF, 2, 16'h7E57, 16'h0000};
        vecs[2] = '{16'h8000, 4, 16'h0000, 16'h8001};
        vecs[3] = '{16'h1233, 3, 16'hFFFF, 16'h1234};
        vecs[4] = '{16'h7FFF, 1, 16'h5555, 16'h8000};

        reset       = 1'b0;
        fetch_req   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        mem_rdata   = 16'h0000;
        mem_valid   = 1'b0;
        repeat (3) tick();
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr_out, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk1("rst_load_en", load_en, 1'b0);
        chk1("rst_mem_rd_en", mem_rd_en, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        reset = 1'b1;

`ifndef IFETCH_PREFETCH_EN
        // Scenario 1: fetch from 0x0000, data two cycles after the strobe.
        do_fetch(16'h0000, 2, 16'h1234);
        chk("s1_pc", pc, 16'h0001);
        chk1("s1_busy", busy, 1'b0);
        tick();
        chk1("s1_single_load", load_en, 1'b0);

        // Table of fetches, including the 0xFFFF wrap.
        for (int i = 0; i < 5; i++) begin
            set_pc(vecs[i].start_pc);
            do_fetch(vecs[i].start_pc, vecs[i].lat, vecs[i].data);
            chk("vec_pc", pc, vecs[i].next_pc);
            chk("vec_instr", instr_out, vecs[i].data);
            chk1("vec_busy", busy, 1'b0);
        end

        // Redirect in IDLE wins over a simultaneous fetch_req.
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        fetch_req   = 1'b1;
        tick();
        redirect  = 1'b0;
        fetch_req = 1'b0;
        chk1("idle_redir_busy", busy, 1'b0);
        tick();
        chk1("idle_redir_no_rd", mem_rd_en, 1'b0);
        chk("idle_redir_pc", pc, 16'h0100);

        // mem_valid in IDLE is ignored.
        mem_valid = 1'b1;
        mem_rdata = 16'h9999;
        tick();
        mem_valid = 1'b0;
        chk1("idle_valid_no_load", load_en, 1'b0);
        chk1("idle_valid_busy", busy, 1'b0);

        // Scenario 3: redirect during WAIT, stale response dropped.
        prev_instr = instr_out;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk("s3_pc", pc, 16'h0040);
        chk1("s3_drain_busy", busy, 1'b1);
        mem_valid = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_valid = 1'b0;
        chk1("s3_no_load", load_en, 1'b0);
        chk("s3_instr", instr_out, prev_instr);
        chk1("s3_idle", busy, 1'b0);
        do_fetch(16'h0040, 2, 16'h4040);
        chk("s3_next_pc", pc, 16'h0041);

        // Redirect in ISSUE, then again in DRAIN.
        fetch_req = 1'b1;
        tick();
        fetch_req   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0300;
        tick();
        redirect_pc = 16'h0400;
        chk1("issue_redir_busy", busy, 1'b1);
        tick();
        redirect = 1'b0;
        chk("drain_redir_pc", pc, 16'h0400);
        chk1("drain_redir_busy", busy, 1'b1);
        mem_valid = 1'b1;
        mem_rdata = 16'h0BAD;
        tick();
        mem_valid = 1'b0;
        chk1("drain_no_load", load_en, 1'b0);
        chk1("drain_idle", busy, 1'b0);

        // Scenario 4: redirect coincides with mem_valid.
        prev_instr = instr_out;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        mem_valid   = 1'b1;
        mem_rdata   = 16'hCAFE;
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        mem_valid = 1'b0;
        redirect  = 1'b0;
        chk1("s4_no_load", load_en, 1'b0);
        chk("s4_instr", instr_out, prev_instr);
        chk1("s4_idle", busy, 1'b0);
        chk("s4_pc", pc, 16'h0200);

        // Scenario 5: reset during WAIT, then a late response.
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("s5_rst_pc", pc, RST_PC);
        chk1("s5_rst_busy", busy, 1'b0);
        mem_valid = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_valid = 1'b0;
        chk1("s5_no_load", load_en, 1'b0);
        chk("s5_instr", instr_out, 16'h0000);
        chk("s5_pc", pc, RST_PC);
        chk1("s5_busy", busy, 1'b0);
`else
        // Prefetch: the block reads RESET_PC on its own after reset.
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 8 && !seen; i++) begin
                tick();
                if (mem_rd_en === 1'b1) seen = 1'b1;
            end
            chk1("pf_issue_seen", seen, 1'b1);
        end
        chk("pf_addr", mem_addr, RST_PC);
        tick();
        tick();
        mem_valid = 1'b1;
        mem_rdata = 16'h1111;
        tick();
        mem_valid = 1'b0;
        chk1("pf_buffered_no_load", load_en, 1'b0);
        chk1("pf_idle", busy, 1'b0);
        fetch_req = 1'b1;
        exp_q.push_back(16'h1111);
        tick();
        fetch_req = 1'b0;
        chk1("pf_load_next_cycle", load_en, 1'b1);
        chk("pf_pc", pc, RST_PC + STEP);
`endif

        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_loads: got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
